muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter SHORTCUT_EN, default 1, meaning: 1 enables the zero-operand, divide-by-zero and signed-overflow shortcut paths; 0 sends every op to the multiplier/divider.
REQ-002 SHALL have port i_clk_n, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port i_valid, input, 1 bit: upstream op valid.
REQ-005 SHALL have port o_ready, output, 1 bit: op accepted on the edge where i_valid && o_ready.
REQ-006 SHALL have ports i_a / i_b, input, 32 bits each: operands rs1 / rs2.
REQ-007 SHALL have port i_funct3, input, 3 bits: RV32M op (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-008 SHALL have port i_kill, input, 1 bit: pipeline flush; abandons the in-flight op.
REQ-009 SHALL have port o_valid, output, 1 bit: result available.
REQ-010 SHALL have port i_ready, input, 1 bit: downstream accepts result when o_valid && i_ready.
REQ-011 SHALL have port o_result, output, 32 bits: registered result.
REQ-012 SHALL have ports o_md_a / o_md_b, output, 32 bits each, and o_md_funct3, output, 3 bits: latched operands/function to the mul/div unit.
REQ-013 SHALL have port o_md_en, output, 1 bit: one-cycle start pulse to the mul/div unit.
REQ-014 SHALL have ports i_md_result, input, 32 bits, and i_md_busy, input, 1 bit: mul/div result and busy.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE and DRAIN.
REQ-016 SHALL drive o_ready = (state==IDLE) && !i_kill && !i_md_busy.
REQ-017 SHALL, on accept, latch i_a, i_b and i_funct3 into the o_md_* registers, which hold stable until the next accept.
REQ-018 SHALL define shortcut (SHORTCUT_EN=1) as: mul op with a==0 or b==0 -> 0; DIV/DIVU with b==0 -> 0xFFFFFFFF; REM/REMU with b==0 -> a; DIV with a==0x80000000, b==0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-019 SHALL, on accept of a shortcut op, load o_result and go IDLE->DONE (o_valid the cycle after accept), with no o_md_en.
REQ-020 SHALL, on accept of a non-shortcut op, go IDLE->ISSUE.
REQ-021 SHALL assert o_md_en for exactly the ISSUE cycle, then go ISSUE->WAIT.
REQ-022 SHALL stay in WAIT while i_md_busy=1; on the first WAIT cycle with i_md_busy=0, capture i_md_result into o_result and go WAIT->DONE.
REQ-023 SHALL assert o_valid only in DONE, holding o_result constant there; on i_ready go DONE->IDLE.
REQ-024 SHALL give a latency of 3 cycles plus busy length: MULHU 7x6 with 3-cycle busy gives o_valid 6 cycles after accept; a division with 32-cycle busy gives 35.
REQ-025 SHALL handle i_kill: in IDLE, no accept; in ISSUE, suppress o_md_en and go IDLE; in WAIT, go DRAIN; in DONE, drop o_valid and go IDLE; in DRAIN, no effect.
REQ-026 SHALL stay in DRAIN until i_md_busy=0, then go IDLE discarding i_md_result, with no o_valid.
REQ-027 SHALL give i_kill priority over i_valid and i_ready in the same cycle.
REQ-028 SHALL have no second op in flight: o_ready=0 in ISSUE, WAIT, DONE and DRAIN.

Reset
REQ-029 SHALL, while i_rst_n=0, immediately force state IDLE, o_valid=0, o_md_en=0, o_result=0, o_md_a=0, o_md_b=0 and o_md_funct3=0.
REQ-030 SHALL, on reset assertion mid-operation, abandon the op with no o_valid after release; the mul/div unit is reset alongside.

Verification
REQ-031 SHALL be verified with: MUL a=7, b=6 -> one o_md_en pulse, o_result=42, o_valid after busy falls.
REQ-032 SHALL be verified with: DIV a=0xFFFFFF9C (-100), b=7 -> o_result=0xFFFFFFF2 (-14), o_valid 35 cycles after accept; REM with the same operands -> 0xFFFFFFFE (-2).
REQ-033 SHALL be verified with: DIVU b=0, REMU a=0x1234 b=0, and DIV 0x80000000/0xFFFFFFFF -> 0xFFFFFFFF, 0x1234 and 0x80000000, o_valid 1 cycle after accept, o_md_en never asserted.
REQ-034 SHALL be verified with: i_kill in the 10th WAIT cycle of DIVU -> DRAIN, o_ready=0 until i_md_busy falls, no o_valid, next op accepted normally.
REQ-035 SHALL be verified with: i_ready=0 for 5 cycles in DONE -> o_valid=1 and o_result unchanged throughout; accept on the 6th cycle -> IDLE.
REQ-036 SHALL be verified with: i_rst_n pulsed low mid-WAIT -> all outputs 0 immediately; after release, MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// RV32M issue/handshake controller in front of an iterative multiplier/divider.
// Latches operands, short-circuits trivial ops, and handles flush and backpressure.
module muldiv_ctrl #(
    parameter int unsigned SHORTCUT_EN = 1
) (
    input  logic        i_clk_n,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_funct3,
    input  logic        i_kill,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic [31:0] o_md_a,
    output logic [31:0] o_md_b,
    output logic [2:0]  o_md_funct3,
    output logic        o_md_en,
    input  logic [31:0] i_md_result,
    input  logic        i_md_busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic [31:0] md_a_q, md_a_d;
    logic [31:0] md_b_q, md_b_d;
    logic [2:0]  md_funct3_q, md_funct3_d;

    logic        accept;
    logic        sc_hit;
    logic [31:0] sc_val;
    logic        b_zero;
    logic        div_ovf;

    assign o_ready     = (state_q == IDLE) && !i_kill && !i_md_busy;
    assign accept      = i_valid && o_ready;
    assign o_result    = result_q;
    assign o_md_a      = md_a_q;
    assign o_md_b      = md_b_q;
    assign o_md_funct3 = md_funct3_q;

    assign b_zero  = (i_b == '0);
    assign div_ovf = (i_a == 32'h8000_0000) && (i_b == '1);

    // Results that are known from the operands alone never reach the unit.
    always_comb begin
        sc_hit = 1'b0;
        sc_val = '0;
        if (SHORTCUT_EN != 0) begin
            case (i_funct3)
                3'b000, 3'b001, 3'b010, 3'b011: begin
                    if ((i_a == '0) || b_zero) begin
                        sc_hit = 1'b1;
                        sc_val = '0;
                    end
                end
                3'b100: begin
                    if (b_zero) begin
                        sc_hit = 1'b1;
                        sc_val = '1;
                    end else if (div_ovf) begin
                        sc_hit = 1'b1;
                        sc_val = 32'h8000_0000;
                    end
                end
                3'b101: begin
                    if (b_zero) begin
                        sc_hit = 1'b1;
                        sc_val = '1;
                    end
                end
                3'b110: begin
                    if (b_zero) begin
                        sc_hit = 1'b1;
                        sc_val = i_a;
                    end else if (div_ovf) begin
                        sc_hit = 1'b1;
                        sc_val = '0;
                    end
                end
                default: begin
                    if (b_zero) begin
                        sc_hit = 1'b1;
                        sc_val = i_a;
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        md_a_d      = md_a_q;
        md_b_d      = md_b_q;
        md_funct3_d = md_funct3_q;
        o_md_en     = 1'b0;
        o_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    md_a_d      = i_a;
                    md_b_d      = i_b;
                    md_funct3_d = i_funct3;
                    if (sc_hit) begin
                        result_d = sc_val;
                        state_d  = DONE;
                    end else begin
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (i_kill) begin
                    state_d = IDLE;
                end else begin
                    o_md_en = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (i_kill) begin
                    state_d = DRAIN;
                end else if (!i_md_busy) begin
                    result_d = i_md_result;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // Kill hides the result this cycle so no handshake can complete.
                o_valid = !i_kill;
                if (i_kill || i_ready) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (!i_md_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_n or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            md_a_q      <= '0;
            md_b_q      <= '0;
            md_funct3_q <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            md_a_q      <= md_a_d;
            md_b_q      <= md_b_d;
            md_funct3_q <= md_funct3_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural multi-cycle mul/div unit.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [2:0]  i_funct3;
    logic        i_kill;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [31:0] o_md_a;
    logic [31:0] o_md_b;
    logic [2:0]  o_md_funct3;
    logic        o_md_en;
    logic [31:0] md_res;
    logic        md_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    int busy_len = 3;
    logic [5:0] busy_cnt;

    muldiv_ctrl #(.SHORTCUT_EN(1)) dut (
        .i_clk_n     (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_funct3    (i_funct3),
        .i_kill      (i_kill),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_md_a      (o_md_a),
        .o_md_b      (o_md_b),
        .o_md_funct3 (o_md_funct3),
        .o_md_en     (o_md_en),
        .i_md_result (md_res),
        .i_md_busy   (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] md_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] f);
        logic [63:0] ea, eb, p;
        ea = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (f == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        case (f)
            3'b000: return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Mul/div unit: busy for busy_len cycles after the start pulse, reset with the controller.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
            md_res   <= '0;
        end else if (o_md_en) begin
            busy_cnt <= 6'(busy_len);
            md_res   <= md_model(o_md_a, o_md_b, o_md_funct3);
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 6'd1;
        end
    end
    assign md_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        if (o_md_en) en_cnt <= en_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present an op, wait for accept, then count cycles until o_valid (1 = cycle after accept).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                          output int lat, output logic [31:0] res, output int ens);
        int e0;
        int guard;
        e0 = en_cnt;
        i_a = a;
        i_b = b;
        i_funct3 = f;
        i_valid = 1'b1;
        guard = 0;
        while (!o_ready && guard < 100) begin
            tick;
            guard++;
        end
        tick;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 200) begin
            tick;
            lat++;
        end
        res = o_result;
        ens = en_cnt - e0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_kill = 1'b0;
        i_ready = 1'b1;
        i_a = '0;
        i_b = '0;
        i_funct3 = '0;
        #2;
        n_checks++;
        if ({o_valid, o_md_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid/en=%b required 00", {o_valid, o_md_en});
        end
        n_checks++;
        if ({o_result, o_md_a, o_md_b, o_md_funct3} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: result=%h a=%h b=%h f=%h required all 0",
                     o_result, o_md_a, o_md_b, o_md_funct3);
        end
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: o_ready=%b required 1", o_ready);
        end
    endtask

    task automatic test_mul;
        int lat, ens;
        logic [31:0] res;
        busy_len = 3;
        run_op(32'd7, 32'd6, 3'b000, lat, res, ens);
        n_checks++;
        if (res !== 32'd42) begin
            n_fail++;
            $display("FAIL mul_result: got %h required %h", res, 32'd42);
        end
        n_checks++;
        if (lat != 6) begin
            n_fail++;
            $display("FAIL mul_latency: got %0d required 6", lat);
        end
        n_checks++;
        if (ens != 1) begin
            n_fail++;
            $display("FAIL mul_en_pulses: got %0d required 1", ens);
        end
        n_checks++;
        if ({o_md_a, o_md_b, o_md_funct3} !== {32'd7, 32'd6, 3'b000}) begin
            n_fail++;
            $display("FAIL mul_latched: a=%h b=%h f=%h required 7 6 0", o_md_a, o_md_b, o_md_funct3);
        end
        tick;
        n_checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL mul_handshake: valid/ready=%b required 01", {o_valid, o_ready});
        end
        run_op(32'd7, 32'd6, 3'b011, lat, res, ens);
        n_checks++;
        if (res !== 32'd0 || lat != 6) begin
            n_fail++;
            $display("FAIL mulhu_small: result=%h lat=%0d required 0 and 6", res, lat);
        end
        tick;
    endtask

    task automatic test_div;
        int lat, ens;
        logic [31:0] res;
        busy_len = 32;
        run_op(32'hFFFF_FF9C, 32'd7, 3'b100, lat, res, ens);
        n_checks++;
        if (res !== 32'hFFFF_FFF2) begin
            n_fail++;
            $display("FAIL div_result: got %h required fffffff2", res);
        end
        n_checks++;
        if (lat != 35 || ens != 1) begin
            n_fail++;
            $display("FAIL div_latency: lat=%0d en=%0d required 35 and 1", lat, ens);
        end
        tick;
        run_op(32'hFFFF_FF9C, 32'd7, 3'b110, lat, res, ens);
        n_checks++;
        if (res !== 32'hFFFF_FFFE || lat != 35) begin
            n_fail++;
            $display("FAIL rem_result: got %h lat=%0d required fffffffe and 35", res, lat);
        end
        tick;
    endtask

    logic [31:0] sc_a   [6] = '{32'h55, 32'h0, 32'h1234, 32'h9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] sc_b   [6] = '{32'h0, 32'h5, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [2:0]  sc_f   [6] = '{3'b101, 3'b000, 3'b111, 3'b001, 3'b100, 3'b110};
    logic [31:0] sc_exp [6] = '{32'hFFFF_FFFF, 32'h0, 32'h1234, 32'h0, 32'h8000_0000, 32'h0};

    task automatic test_shortcut;
        int lat, ens;
        logic [31:0] res;
        busy_len = 32;
        for (int i = 0; i < 6; i++) begin
            run_op(sc_a[i], sc_b[i], sc_f[i], lat, res, ens);
            n_checks++;
            if (res !== sc_exp[i]) begin
                n_fail++;
                $display("FAIL shortcut_result[%0d]: got %h required %h", i, res, sc_exp[i]);
            end
            n_checks++;
            if (lat != 1) begin
                n_fail++;
                $display("FAIL shortcut_latency[%0d]: got %0d required 1", i, lat);
            end
            n_checks++;
            if (ens != 0) begin
                n_fail++;
                $display("FAIL shortcut_en[%0d]: got %0d pulses required 0", i, ens);
            end
            tick;
        end
    endtask

    task automatic test_kill_wait;
        int lat, ens, guard;
        logic [31:0] res;
        logic bad;
        busy_len = 32;
        i_a = 32'd1000;
        i_b = 32'd3;
        i_funct3 = 3'b101;
        i_valid = 1'b1;
        tick;
        i_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick;
        i_kill = 1'b1;
        tick;
        i_kill = 1'b0;
        bad = 1'b0;
        guard = 0;
        while (md_busy && guard < 64) begin
            if (o_ready !== 1'b0 || o_valid !== 1'b0) bad = 1'b1;
            tick;
            guard++;
        end
        n_checks++;
        if (bad !== 1'b0 || guard == 0 || guard >= 64) begin
            n_fail++;
            $display("FAIL kill_drain: ready/valid seen=%b drain cycles=%0d required 0 and 1..63",
                     bad, guard);
        end
        tick;
        n_checks++;
        if ({o_ready, o_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL kill_idle: ready/valid=%b required 10", {o_ready, o_valid});
        end
        busy_len = 3;
        run_op(32'd7, 32'd6, 3'b000, lat, res, ens);
        n_checks++;
        if (res !== 32'd42 || lat != 6 || ens != 1) begin
            n_fail++;
            $display("FAIL kill_next_op: result=%h lat=%0d en=%0d required 2a 6 1", res, lat, ens);
        end
        tick;
    endtask

    task automatic test_kill_issue;
        int e0;
        e0 = en_cnt;
        i_a = 32'd3;
        i_b = 32'd3;
        i_funct3 = 3'b000;
        i_valid = 1'b1;
        tick;
        i_valid = 1'b0;
        i_kill = 1'b1;
        #1;
        n_checks++;
        if (o_md_en !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_issue_en: o_md_en=%b required 0", o_md_en);
        end
        tick;
        i_kill = 1'b0;
        #1;
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || en_cnt != e0) begin
            n_fail++;
            $display("FAIL kill_issue_idle: ready=%b valid=%b en=%0d required 1 0 0",
                     o_ready, o_valid, en_cnt - e0);
        end
    endtask

    task automatic test_backpressure;
        int lat, ens;
        logic [31:0] res;
        logic bad;
        busy_len = 3;
        i_ready = 1'b0;
        run_op(32'h0001_0000, 32'h0003_0000, 3'b001, lat, res, ens);
        n_checks++;
        if (res !== 32'd3 || lat != 6) begin
            n_fail++;
            $display("FAIL bp_result: got %h lat=%0d required 3 and 6", res, lat);
        end
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (o_valid !== 1'b1 || o_result !== 32'd3 || o_ready !== 1'b0) bad = 1'b1;
            tick;
        end
        n_checks++;
        if (bad !== 1'b0 || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: unstable=%b valid=%b required 0 and 1", bad, o_valid);
        end
        i_ready = 1'b1;
        tick;
        n_checks++;
        if ({o_valid, o_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: valid/ready=%b required 01", {o_valid, o_ready});
        end
    endtask

    task automatic test_reset_mid;
        int lat, ens;
        logic [31:0] res;
        logic bad;
        busy_len = 32;
        i_a = 32'd500;
        i_b = 32'd9;
        i_funct3 = 3'b100;
        i_valid = 1'b1;
        tick;
        i_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_valid, o_md_en, o_result, o_md_a, o_md_b, o_md_funct3} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: valid=%b en=%b result=%h a=%h b=%h f=%h required all 0",
                     o_valid, o_md_en, o_result, o_md_a, o_md_b, o_md_funct3);
        end
        tick;
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_valid !== 1'b0) bad = 1'b1;
            tick;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_novalid: o_valid seen=%b required 0", bad);
        end
        busy_len = 3;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, lat, res, ens);
        n_checks++;
        if (res !== 32'hFFFF_FFFE || lat != 6) begin
            n_fail++;
            $display("FAIL midreset_mulhu: got %h lat=%0d required fffffffe and 6", res, lat);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_shortcut;
        test_kill_wait;
        test_kill_issue;
        test_backpressure;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
